// File: rtl/sw_alloc.sv
// Switch allocator: one round-robin arbiter per output with a packet lock
// that binds the output to its winning input until the tail flit passes.
module sw_alloc #(
    parameter int NPORT = 5,
    parameter int PORTW = 3
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [NPORT-1:0]       req,
    input  logic [NPORT*PORTW-1:0] port,
    input  logic [NPORT-1:0]       tail,
    input  logic [NPORT-1:0]       ordy,
    output logic [NPORT-1:0]       grt,
    output logic [NPORT-1:0]       busy,
    output logic [NPORT*PORTW-1:0] owner
);

    typedef enum logic {IDLE, LOCKED} state_t;

    logic [NPORT*NPORT-1:0] gv;

    for (genvar p = 0; p < NPORT; p++) begin : g_out
        state_t           st_q, st_d;
        logic [PORTW-1:0] own_q, own_d;
        logic [PORTW-1:0] ptr_q, ptr_d;
        logic [PORTW-1:0] win, idx;
        logic [NPORT-1:0] cand, g;
        logic             hit;

        // Indices >= NPORT never compare equal to a real output.
        always_comb begin
            for (int i = 0; i < NPORT; i++) begin
                cand[i] = req[i] && (port[i*PORTW +: PORTW] == PORTW'(p));
            end
        end

        always_comb begin
            win = ptr_q;
            hit = 1'b0;
            idx = ptr_q;
            for (int k = 0; k < NPORT; k++) begin
                if (!hit && cand[idx]) begin
                    hit = 1'b1;
                    win = idx;
                end
                idx = (idx == PORTW'(NPORT - 1)) ? '0 : idx + 1'b1;
            end
        end

        always_comb begin
            st_d  = st_q;
            own_d = own_q;
            ptr_d = ptr_q;
            g     = '0;
            unique case (st_q)
                IDLE: begin
                    if (ordy[p] && hit) begin
                        st_d  = LOCKED;
                        own_d = win;
                    end
                end
                LOCKED: begin
                    if (cand[own_q] && ordy[p]) begin
                        g[own_q] = 1'b1;
                        if (tail[own_q]) begin
                            st_d  = IDLE;
                            ptr_d = (own_q == PORTW'(NPORT - 1)) ?
                                    '0 : own_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        always_ff @(posedge clk or posedge rst_) begin
            if (rst_) begin
                st_q  <= IDLE;
                own_q <= '0;
                ptr_q <= '0;
            end else begin
                st_q  <= st_d;
                own_q <= own_d;
                ptr_q <= ptr_d;
            end
        end

        assign busy[p]                  = (st_q == LOCKED);
        assign owner[p*PORTW +: PORTW]  = own_q;
        assign gv[p*NPORT +: NPORT]     = g;
    end

    always_comb begin
        grt = '0;
        for (int p = 0; p < NPORT; p++) begin
            grt = grt | gv[p*NPORT +: NPORT];
        end
    end

endmodule

// File: tb/tb_sw_alloc.sv
// Scoreboard bench for sw_alloc: a per-cycle reference model pushes
// expected outputs, a monitor pops and compares them.
module tb_sw_alloc;

    localparam int N = 5;
    localparam int W = 3;

    logic           clk = 1'b0;
    logic           rst_;
    logic [N-1:0]   req, tail, ordy;
    logic [N*W-1:0] port;
    logic [N-1:0]   grt, busy;
    logic [N*W-1:0] owner;

    sw_alloc #(.NPORT(N), .PORTW(W)) dut (
        .clk(clk), .rst_(rst_), .req(req), .port(port), .tail(tail),
        .ordy(ordy), .grt(grt), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]   grt;
        logic [N-1:0]   busy;
        logic [N*W-1:0] owner;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int m_lock [N];
    int m_own  [N];
    int m_ptr  [N];

    function automatic int pidx(input int i);
        return int'(port[i*W +: W]);
    endfunction

    // Reference: spec rules applied per output on the current inputs.
    task automatic model_step();
        exp_t e;
        e = '0;
        if (rst_) begin
            for (int p = 0; p < N; p++) begin
                m_lock[p] = 0; m_own[p] = 0; m_ptr[p] = 0;
            end
            sb.push_back(e);
            return;
        end
        for (int p = 0; p < N; p++) begin
            e.busy[p] = (m_lock[p] != 0);
            e.owner[p*W +: W] = W'(m_own[p]);
        end
        for (int p = 0; p < N; p++) begin
            if (m_lock[p] != 0) begin
                int o;
                o = m_own[p];
                if (req[o] && pidx(o) == p && ordy[p]) begin
                    e.grt[o] = 1'b1;
                    if (tail[o]) begin
                        m_lock[p] = 0;
                        m_ptr[p] = (o + 1) % N;
                    end
                end
            end else if (ordy[p]) begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (m_ptr[p] + k) % N;
                    if (req[i] && pidx(i) == p) begin
                        m_lock[p] = 1;
                        m_own[p] = i;
                        break;
                    end
                end
            end
        end
        sb.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic [N-1:0] rq,
                       input logic [N*W-1:0] pt, input logic [N-1:0] tl,
                       input logic [N-1:0] od);
        @(negedge clk);
        rst_ = r; req = rq; port = pt; tail = tl; ordy = od;
        #1;
        model_step();
    endtask

    function automatic logic [N*W-1:0] pv(input int a0, input int a1,
        input int a2, input int a3, input int a4);
        return {W'(a4), W'(a3), W'(a2), W'(a1), W'(a0)};
    endfunction

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("grt",   32'(grt),   32'(e.grt));
                check("busy",  32'(busy),  32'(e.busy));
                check("owner", 32'(owner), 32'(e.owner));
            end
        end
    end

    initial begin : driver
        logic [N-1:0]   rq, tl, od;
        logic [N*W-1:0] pt;
        rst_ = 1'b1; req = '0; port = '0; tail = '0; ordy = '0;
        cyc(1, '0, '0, '0, '0);
        cyc(1, '0, '0, '0, '0);

        // Reset mid-lock: input 2 owns output 4.
        repeat (3) cyc(0, 5'b00100, pv(0,0,4,0,0), '0, 5'b10000);
        cyc(1, 5'b00100, pv(0,0,4,0,0), '0, 5'b10000);
        cyc(0, '0, '0, '0, 5'b10000);

        // Single request, four-flit packet to output 3.
        repeat (4) cyc(0, 5'b00001, pv(3,0,0,0,0), '0, 5'b01000);
        cyc(0, 5'b00001, pv(3,0,0,0,0), 5'b00001, 5'b01000);
        cyc(0, '0, '0, '0, 5'b01000);

        // Round-robin on output 1 with single-flit packets.
        repeat (9) cyc(0, 5'b00111, pv(1,1,1,0,0), 5'b11111, 5'b00010);
        cyc(0, '0, '0, '0, '0);

        // Lock hold: input 3 owns output 0, idles while input 4 waits.
        repeat (2) cyc(0, 5'b01000, pv(0,0,0,0,0), '0, 5'b00001);
        repeat (3) cyc(0, 5'b10000, pv(0,0,0,0,0), '0, 5'b00001);
        cyc(0, 5'b11000, pv(0,0,0,0,0), '0, 5'b00001);
        cyc(0, 5'b11000, pv(0,0,0,0,0), 5'b01000, 5'b00001);
        repeat (3) cyc(0, 5'b10000, pv(0,0,0,0,0), 5'b10000, 5'b00001);

        // Backpressure on output 2 owned by input 1.
        cyc(0, 5'b00010, pv(0,2,0,0,0), '0, 5'b00100);
        repeat (5) cyc(0, 5'b00010, pv(0,2,0,0,0), '0, 5'b00000);
        cyc(0, 5'b00010, pv(0,2,0,0,0), 5'b00010, 5'b00100);
        cyc(0, '0, '0, '0, '0);

        // Parallel outputs plus an out-of-range index on input 4.
        repeat (4) cyc(0, 5'b10011, pv(2,3,0,0,6), '0, 5'b11111);
        cyc(0, 5'b10011, pv(2,3,0,0,6), 5'b00011, 5'b11111);

        // Random traffic with sticky destinations and rare resets.
        pt = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0)
                    pt[i*W +: W] = W'($urandom_range(6));
                rq[i] = ($urandom_range(9) < 7);
                tl[i] = ($urandom_range(3) == 0);
                od[i] = ($urandom_range(3) != 0);
            end
            cyc(($urandom_range(299) == 0), rq, pt, tl, od);
        end

        @(negedge clk);
        #5;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
